// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit for the E stage of the 5-stage
// MIPS pipeline. It owns HI/LO and executes mult, multu, div, divu, mthi and
// mtlo. A mult/div result is computed in the accepting cycle and held in a
// pending register. It is committed to HI/LO after MULT_CYCLES or DIV_CYCLES
// cycles of busy. This mimics the latency of an iterative unit.
//
// Ports:
//   clk      in   1   pipeline clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   E-stage instruction is a md op (qualifies md_op)
//   md_op    in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   a        in  32   forwarded rs value
//   b        in  32   forwarded rt value
//   md_in_D  in   1   instruction in D is md-class
//   busy     out  1   operation in flight (registered)
//   done     out  1   one-cycle pulse when HI/LO take a mult/div result
//   hi       out 32   HI register
//   lo       out 32   LO register
//   md_stall out  1   combinational stall request to the hazard unit
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_in_D,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [63:0]   pend_q, pend_d;
    logic          pendWe_q, pendWe_d;
    logic          done_q, done_d;

    logic          startAccept;
    logic [63:0]   prodS, prodU;
    logic          divOvf;
    logic [31:0]   bSafeS, bSafeU;
    logic [31:0]   quoS, remS, quoU, remU;

    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign startAccept = start & ~busy & (md_op != 3'd0) & (md_op != 3'd7);
    assign md_stall    = md_in_D & (busy | startAccept);

    assign prodS = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prodU = {32'd0, a} * {32'd0, b};

    // Divisors are forced to 1 for divide-by-zero (result discarded anyway)
    // and for 0x80000000 / -1, where a/1 yields exactly the architected
    // quotient 0x80000000 and remainder 0 without signed overflow.
    assign divOvf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign bSafeS = ((b == 32'd0) || divOvf) ? 32'd1 : b;
    assign bSafeU = (b == 32'd0) ? 32'd1 : b;
    assign quoS   = $signed(a) / $signed(bSafeS);
    assign remS   = $signed(a) % $signed(bSafeS);
    assign quoU   = a / bSafeU;
    assign remU   = a % bSafeU;

    // Next-state logic: IDLE accepts new ops (mthi/mtlo complete at once),
    // RUN counts down and commits the pending result on the 1->0 step.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        pend_d   = pend_q;
        pendWe_d = pendWe_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (startAccept) begin
                    case (md_op)
                        OP_MULT: begin
                            pend_d   = prodS;
                            pendWe_d = 1'b1;
                            cnt_d    = CW'(MULT_CYCLES);
                            state_d  = RUN;
                        end
                        OP_MULTU: begin
                            pend_d   = prodU;
                            pendWe_d = 1'b1;
                            cnt_d    = CW'(MULT_CYCLES);
                            state_d  = RUN;
                        end
                        OP_DIV: begin
                            pend_d   = {remS, quoS};
                            pendWe_d = (b != 32'd0);
                            cnt_d    = CW'(DIV_CYCLES);
                            state_d  = RUN;
                        end
                        OP_DIVU: begin
                            pend_d   = {remU, quoU};
                            pendWe_d = (b != 32'd0);
                            cnt_d    = CW'(DIV_CYCLES);
                            state_d  = RUN;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (pendWe_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any in-flight op without touching HI/LO
    // beyond clearing them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            pend_q   <= '0;
            pendWe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            pend_q   <= pend_d;
            pendWe_q <= pendWe_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit. Expected HI/LO pairs are
// pushed to a queue when an op is issued and popped when the op retires.
module tb_md_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_in_D;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        md_stall;

    typedef struct packed {
        logic [31:0] eHi;
        logic [31:0] eLo;
    } exp_t;

    exp_t expQ[$];
    int   checks;
    int   failures;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op), .a(a), .b(b),
        .md_in_D(md_in_D), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .md_stall(md_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Drive one start pulse at a negedge, optionally recording the expected result.
    task automatic issueOp(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                           input bit pushExp, input logic [31:0] eHi, input logic [31:0] eLo);
        exp_t e;
        @(negedge clk);
        start = 1'b1; md_op = op; a = av; b = bv;
        if (pushExp) begin
            e.eHi = eHi; e.eLo = eLo;
            expQ.push_back(e);
        end
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
    endtask

    // Count busy cycles (bounded) and capture outputs the cycle busy falls.
    task automatic waitOp(output int busyCount, output int doneEarly,
                          output logic [31:0] hiSeen, output logic [31:0] loSeen,
                          output logic doneAtFall, output logic doneAfter);
        busyCount = 0; doneEarly = 0;
        while (busy === 1'b1 && busyCount < 200) begin
            busyCount++;
            if (done === 1'b1) doneEarly++;
            @(negedge clk);
        end
        hiSeen = hi; loSeen = lo; doneAtFall = done;
        @(negedge clk);
        doneAfter = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; md_op = 3'd0; a = '0; b = '0; md_in_D = 1'b0;
        #12;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", done); end
        checks++; if (hi !== 32'd0) begin failures++; $display("[TB] FAIL reset_hi got=%h want=0", hi); end
        checks++; if (lo !== 32'd0) begin failures++; $display("[TB] FAIL reset_lo got=%h want=0", lo); end
        checks++; if (md_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%b want=0", md_stall); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Retire one op and compare against the scoreboard head.
    task automatic retireAndCheck(input string name, input int wantCycles);
        int          bc, de;
        logic [31:0] hs, ls;
        logic        dF, dA;
        exp_t        e;
        waitOp(bc, de, hs, ls, dF, dA);
        checks++; if (bc != wantCycles) begin failures++; $display("[TB] FAIL %s_busy_cycles got=%0d want=%0d", name, bc, wantCycles); end
        checks++; if (de != 0 || dF !== 1'b1 || dA !== 1'b0) begin failures++; $display("[TB] FAIL %s_done_pulse got early=%0d fall=%b after=%b want 0/1/0", name, de, dF, dA); end
        checks++;
        if (expQ.size() == 0) begin
            failures++; $display("[TB] FAIL %s_scoreboard_empty got=empty want=entry", name);
        end else begin
            e = expQ.pop_front();
            if (hs !== e.eHi || ls !== e.eLo) begin
                failures++; $display("[TB] FAIL %s_result got hi=%h lo=%h want hi=%h lo=%h", name, hs, ls, e.eHi, e.eLo);
            end
        end
    endtask

    task automatic test_mult();
        exp_t e;
        @(negedge clk);
        md_in_D = 1'b1; start = 1'b1; md_op = 3'd1; a = 32'hFFFF_FFFE; b = 32'h0000_0003;
        e.eHi = 32'hFFFF_FFFF; e.eLo = 32'hFFFF_FFFA; expQ.push_back(e);
        #1;
        checks++; if (md_stall !== 1'b1) begin failures++; $display("[TB] FAIL start_cycle_stall got=%b want=1", md_stall); end
        @(negedge clk);
        start = 1'b0; md_op = 3'd0; md_in_D = 1'b0;
        retireAndCheck("mult", 5);
    endtask

    task automatic test_multu();
        issueOp(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
        retireAndCheck("multu", 5);
    endtask

    task automatic test_div();
        issueOp(3'd4, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
        retireAndCheck("divu", 10);
        issueOp(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        retireAndCheck("div_neg", 10);
    endtask

    task automatic test_edge_div();
        issueOp(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000);
        retireAndCheck("div_ovf", 10);
        issueOp(3'd5, 32'h11, 32'd0, 1'b0, 32'd0, 32'd0);
        checks++; if (hi !== 32'h11 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL mthi got hi=%h busy=%b done=%b want 11/0/0", hi, busy, done); end
        issueOp(3'd6, 32'h22, 32'd0, 1'b0, 32'd0, 32'd0);
        checks++; if (lo !== 32'h22 || hi !== 32'h11 || busy !== 1'b0) begin failures++; $display("[TB] FAIL mtlo got hi=%h lo=%h busy=%b want 11/22/0", hi, lo, busy); end
        issueOp(3'd4, 32'd55, 32'd0, 1'b1, 32'h11, 32'h22);
        retireAndCheck("divu_zero", 10);
    endtask

    task automatic test_back_to_back();
        int   k, bc;
        exp_t e;
        issueOp(3'd1, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6);
        md_in_D = 1'b1;
        k = 0; bc = 0;
        while (busy === 1'b1 && k < 200) begin
            #1;
            checks++; if (md_stall !== 1'b1) begin failures++; $display("[TB] FAIL busy_stall k=%0d got=%b want=1", k, md_stall); end
            if (k == 1) begin start = 1'b1; md_op = 3'd6; a = 32'hDEAD; end
            else if (k == 2) begin start = 1'b1; md_op = 3'd1; a = 32'd7; b = 32'd7; end
            else begin start = 1'b0; md_op = 3'd0; end
            k++; bc++;
            @(negedge clk);
        end
        #1;
        checks++; if (bc != 5) begin failures++; $display("[TB] FAIL ignore_busy_cycles got=%0d want=5", bc); end
        checks++; if (md_stall !== 1'b0) begin failures++; $display("[TB] FAIL stall_at_fall got=%b want=0", md_stall); end
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL ignore_done got=%b want=1", done); end
        e = expQ.pop_front();
        checks++; if (hi !== e.eHi || lo !== e.eLo) begin failures++; $display("[TB] FAIL ignore_result got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.eHi, e.eLo); end
        md_in_D = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL ignore_no_restart got busy=%b done=%b want 0/0", busy, done); end
    endtask

    task automatic test_async_reset();
        issueOp(3'd3, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL async_rst_ctrl got busy=%b done=%b want 0/0", busy, done); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("[TB] FAIL async_rst_hilo got hi=%h lo=%h want 0/0", hi, lo); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("[TB] FAIL aborted_div got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo); end
        issueOp(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        retireAndCheck("mult_after_rst", 5);
    endtask

    initial begin
        checks = 0; failures = 0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_edge_div();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
